y_if_prefetch: RTL and testbench

Y_IF_PREFETCH -- requirements
Module: y_if_prefetch

---
 rtl/y_pipe_pkg.sv | 17 +
 rtl/y_fifo.sv | 62 ++++++
 rtl/y_if_prefetch.sv | 123 ++++++++++++
 tb/tb_y_if_prefetch.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y_pipe_pkg.sv
// Shared fetch-pipeline constants and types: default geometry, reset PC,
// NOP encoding and the request-control state encoding.
package y_pipe_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_DEPTH = 4;
  localparam logic [31:0] DEF_ENTRY = 32'd128;
  localparam logic [31:0] NOP       = 32'h0000_0000;
  localparam int unsigned INS_W     = 32;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/y_fifo.sv
// Prefetch buffer: power-of-two circular FIFO with flush and occupancy count.
// The head word is read straight from storage, so it never depends on wdata.
module y_fifo
  import y_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [DATA_W-1:0]       wdata,
  output logic [DATA_W-1:0]       rdata,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Popping an empty buffer or pushing a full one is silently ignored.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && (count != FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/y_if_prefetch.sv
// Instruction-fetch prefetcher: keeps one memory read in flight, buffers the
// returned words with their PC+4, and discards stale data after a redirect.
module y_if_prefetch
  import y_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH = DEF_WIDTH,
  parameter int unsigned      DEPTH = DEF_DEPTH,
  parameter logic [WIDTH-1:0] ENTRY = WIDTH'(DEF_ENTRY)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    redirect,
  input  logic [WIDTH-1:0]        redirect_pc,
  output logic                    imem_req,
  output logic [WIDTH-1:0]        imem_addr,
  input  logic                    imem_ack,
  input  logic [31:0]             imem_rdata,
  output logic                    ins_valid,
  output logic [31:0]             ins,
  output logic [WIDTH-1:0]        PCp4,
  input  logic                    ins_ready,
  output logic [$clog2(DEPTH):0]  count,
  output fetch_state_t            fsm_state
);

  // Handshakes: imem_req/imem_addr are held from issue until the single
  // imem_ack that completes them; a head word moves to decode on any cycle
  // where ins_valid && ins_ready, and a redirect overrides both transfers.

  localparam int unsigned         CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned         ENT_W  = INS_W + WIDTH;
  localparam logic [CNT_W-1:0]    FULL   = CNT_W'(DEPTH);
  localparam logic [WIDTH-1:0]    ALIGN  = ~(WIDTH'(3));
  localparam logic [WIDTH-1:0]    STEP   = WIDTH'(4);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [WIDTH-1:0]  fetch_pc;
  logic [WIDTH-1:0]  req_addr;
  logic [WIDTH-1:0]  target_pc;
  logic              issue;
  logic              push;
  logic              pop;
  logic [ENT_W-1:0]  push_word;
  logic [ENT_W-1:0]  head;

  assign target_pc = redirect_pc & ALIGN;

  // WAIT holds a live request; DROP holds one whose data is already stale.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    push       = 1'b0;
    unique case (state)
      FETCH_IDLE: begin
        if (!redirect && (count < FULL)) begin
          issue      = 1'b1;
          state_next = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (imem_ack) begin
          push       = !redirect;
          state_next = FETCH_IDLE;
        end else if (redirect) begin
          state_next = FETCH_DROP;
        end
      end
      FETCH_DROP: begin
        if (imem_ack) begin
          state_next = FETCH_IDLE;
        end
      end
      default: state_next = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH_IDLE;
      fetch_pc <= ENTRY & ALIGN;
      req_addr <= '0;
    end else begin
      state <= state_next;
      if (redirect) begin
        fetch_pc <= target_pc;
      end else if (push) begin
        fetch_pc <= fetch_pc + STEP;
      end
      if (issue) begin
        req_addr <= fetch_pc;
      end
    end
  end

  // While a request is in flight the address comes from req_addr, so a
  // redirect can move fetch_pc without disturbing the bus.
  assign imem_req  = !rst && (issue || (state != FETCH_IDLE));
  assign imem_addr = rst ? '0 : ((state == FETCH_IDLE) ? fetch_pc : req_addr);

  assign push_word = {imem_rdata, req_addr + STEP};
  assign pop       = ins_valid && ins_ready;

  y_fifo #(
    .DATA_W (ENT_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (push_word),
    .rdata (head),
    .count (count)
  );

  assign ins_valid = (count != '0);
  assign ins       = head[ENT_W-1:WIDTH];
  assign PCp4      = head[WIDTH-1:0];
  assign fsm_state = state;

endmodule

// File: tb/tb_y_if_prefetch.sv
// Directed bench for y_if_prefetch: a small memory responder plus an
// expected-word queue checks every buffer pop, request and occupancy.
module tb_y_if_prefetch;
  import y_pipe_pkg::*;

  localparam int unsigned DEPTH      = 4;
  localparam logic [31:0] ENTRY_M    = 32'd128;
  localparam logic [31:0] WRAP_ENTRY = 32'hFFFF_FFF8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         redirect;
  logic [31:0]  redirect_pc;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_ack;
  logic [31:0]  imem_rdata;
  logic         ins_valid;
  logic [31:0]  ins;
  logic [31:0]  PCp4;
  logic         ins_ready;
  logic [2:0]   count;
  fetch_state_t fsm_state;

  logic         w_req;
  logic [31:0]  w_addr;
  logic         w_ack;
  logic [31:0]  w_rdata;
  logic         w_valid;
  logic [31:0]  w_ins;
  logic [31:0]  w_pcp4;
  logic         w_ready;
  logic [2:0]   w_count;
  fetch_state_t w_state;

  y_if_prefetch #(.WIDTH(32), .DEPTH(DEPTH), .ENTRY(ENTRY_M)) u_dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ins_valid(ins_valid), .ins(ins), .PCp4(PCp4),
    .ins_ready(ins_ready), .count(count), .fsm_state(fsm_state)
  );

  y_if_prefetch #(.WIDTH(32), .DEPTH(DEPTH), .ENTRY(WRAP_ENTRY)) u_wrap (
    .clk(clk), .rst(rst), .redirect(1'b0), .redirect_pc(32'd0),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack),
    .imem_rdata(w_rdata), .ins_valid(w_valid), .ins(w_ins), .PCp4(w_pcp4),
    .ins_ready(w_ready), .count(w_count), .fsm_state(w_state)
  );

  // ---------------- scoreboard state ----------------
  logic [63:0] exp_q[$];
  logic [31:0] pop_log[$];
  int          checks = 0;
  int          errors = 0;
  logic        pending;
  logic        pend_drop;
  logic [31:0] pend_addr;
  logic [31:0] model_pc;
  int          wait_cnt;
  int          ack_cnt;
  logic        mem_on;
  int          mem_lat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called once per cycle after inputs settle, before the rising edge.
  task automatic observe();
    logic [63:0] e;
    logic        fresh;
    fresh = 1'b0;
    if (rst) begin
      exp_q.delete();
      pending   = 1'b0;
      pend_drop = 1'b0;
      model_pc  = ENTRY_M;
    end else begin
      chk("count", 64'(count), 64'(exp_q.size()));
      chk("ins_valid", 64'(ins_valid), 64'(exp_q.size() != 0));
      if (pending) begin
        chk("req_hold", 64'(imem_req), 64'd1);
        chk("addr_hold", 64'(imem_addr), 64'(pend_addr));
      end else if (redirect) begin
        chk("req_blocked", 64'(imem_req), 64'd0);
      end else begin
        chk("req_issue", 64'(imem_req), 64'(exp_q.size() < DEPTH));
        if (imem_req) begin
          chk("req_addr", 64'(imem_addr), 64'(model_pc));
          pending   = 1'b1;
          fresh     = 1'b1;
          pend_addr = imem_addr;
          wait_cnt  = 0;
          model_pc  = model_pc + 32'd4;
        end
      end
      if (redirect) begin
        exp_q.delete();
        model_pc = redirect_pc & 32'hFFFF_FFFC;
      end else if (ins_valid && ins_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("ins", 64'(ins), 64'(e[63:32]));
        chk("pcp4", 64'(PCp4), 64'(e[31:0]));
        pop_log.push_back(PCp4);
      end
      if (pending && !fresh) begin
        if (imem_ack) begin
          if (!redirect && !pend_drop) exp_q.push_back({imem_rdata, pend_addr + 32'd4});
          pending   = 1'b0;
          pend_drop = 1'b0;
          ack_cnt++;
        end else if (redirect) begin
          pend_drop = 1'b1;
        end else begin
          wait_cnt++;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Entered and left at posedge+2; one-shot inputs fall back after the edge.
  task automatic cycle();
    if (mem_on && pending && wait_cnt >= mem_lat) begin
      imem_ack   = 1'b1;
      imem_rdata = $urandom;
    end
    #1;
    observe();
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    redirect = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic wait_pending(input logic [31:0] addr, input string tag);
    int n = 0;
    while (!(pending && pend_addr == addr) && n < 40) begin
      cycle();
      n++;
    end
    chk(tag, 64'(pending && pend_addr == addr), 64'd1);
  endtask

  task automatic wait_fill(input int unsigned lvl, input string tag);
    int n = 0;
    while (!(pending && count == 3'(lvl)) && n < 40) begin
      cycle();
      n++;
    end
    chk(tag, 64'(pending && count == 3'(lvl)), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_ack = 1'b0; imem_rdata = '0;
    ins_ready = 1'b0; w_ack = 1'b0; w_rdata = '0; w_ready = 1'b0;
    pending = 1'b0; pend_drop = 1'b0; pend_addr = '0; model_pc = ENTRY_M;
    wait_cnt = 0; ack_cnt = 0; mem_on = 1'b0; mem_lat = 0;
    @(posedge clk);
    #2;
    cycle();
    cycle();
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    chk("rst_valid", 64'(ins_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ins", 64'(ins), 64'd0);
    chk("rst_pcp4", 64'(PCp4), 64'd0);
    rst = 1'b0;
    #1;
    chk("first_req", 64'(imem_req), 64'd1);
    chk("first_addr", 64'(imem_addr), 64'(ENTRY_M));

    // Streaming with immediate acks and an always-ready decoder.
    mem_on = 1'b1; mem_lat = 0; ins_ready = 1'b1;
    pop_log.delete();
    repeat (14) cycle();
    chk("stream_pops", 64'(pop_log.size() >= 3), 64'd1);
    if (pop_log.size() >= 3) begin
      chk("stream_pc0", 64'(pop_log[0]), 64'd132);
      chk("stream_pc1", 64'(pop_log[1]), 64'd136);
      chk("stream_pc2", 64'(pop_log[2]), 64'd140);
    end

    // Stalled decoder fills the buffer and stops requesting.
    do_reset();
    ins_ready = 1'b0; ack_cnt = 0;
    repeat (20) cycle();
    chk("fill_acks", 64'(ack_cnt), 64'd4);
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_req", 64'(imem_req), 64'd0);
    ins_ready = 1'b1;
    cycle();
    ins_ready = 1'b0;
    chk("pop1_count", 64'(count), 64'd3);
    chk("pop1_req", 64'(imem_req), 64'd1);
    ins_ready = 1'b1;
    repeat (16) cycle();

    // Redirect while a request is outstanding: its data must be dropped.
    mem_lat = 3;
    redirect = 1'b1; redirect_pc = 32'h0000_0093;
    cycle();
    wait_pending(32'h90, "wait_req_90");
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    cycle();
    chk("drop_state", 64'(fsm_state), 64'(FETCH_DROP));
    chk("drop_req_hold", 64'(imem_req), 64'd1);
    chk("drop_addr_hold", 64'(imem_addr), 64'h90);
    n = 0;
    while (!ins_valid && n < 40) begin
      cycle();
      n++;
    end
    chk("after_drop_pcp4", 64'(PCp4), 64'h204);
    repeat (6) cycle();

    // Redirect coincident with ack and pop at count 2.
    mem_lat = 0; ins_ready = 1'b0;
    wait_fill(2, "wait_count2");
    mem_on = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; ins_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h0000_0400;
    cycle();
    chk("coinc_count", 64'(count), 64'd0);
    chk("coinc_valid", 64'(ins_valid), 64'd0);
    chk("coinc_req", 64'(imem_req), 64'd1);
    chk("coinc_addr", 64'(imem_addr), 64'h400);
    mem_on = 1'b1;
    repeat (10) cycle();

    // Reset with a partly full buffer and a request in flight.
    ins_ready = 1'b0;
    wait_fill(3, "wait_count3");
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    cycle();
    chk("mrst_req", 64'(imem_req), 64'd0);
    chk("mrst_addr", 64'(imem_addr), 64'd0);
    chk("mrst_valid", 64'(ins_valid), 64'd0);
    chk("mrst_count", 64'(count), 64'd0);
    chk("mrst_ins", 64'(ins), 64'd0);
    chk("mrst_pcp4", 64'(PCp4), 64'd0);
    rst = 1'b0;
    #1;
    chk("mrst_new_req", 64'(imem_req), 64'd1);
    chk("mrst_new_addr", 64'(imem_addr), 64'(ENTRY_M));
    ins_ready = 1'b1;
    repeat (10) cycle();

    // Address wrap on the second instance.
    mem_on = 1'b0;
    do_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] exp_a;
      int guard = 0;
      exp_a = WRAP_ENTRY + 32'(4 * i);
      while (!w_req && guard < 8) begin
        cycle();
        guard++;
      end
      chk("wrap_req", 64'(w_req), 64'd1);
      chk("wrap_addr", 64'(w_addr), 64'(exp_a));
      cycle();
      w_ack = 1'b1; w_rdata = 32'h0000_1000 + 32'(i);
      cycle();
      w_ack = 1'b0;
    end
    chk("wrap_count", 64'(w_count), 64'd3);
    chk("wrap_head_ins", 64'(w_ins), 64'h1000);
    chk("wrap_head_pcp4", 64'(w_pcp4), 64'hFFFF_FFFC);
    w_ready = 1'b1;
    cycle();
    w_ready = 1'b0;
    chk("wrap_ins1", 64'(w_ins), 64'h1001);
    chk("wrap_pcp4_1", 64'(w_pcp4), 64'h0);
    w_ready = 1'b1;
    cycle();
    w_ready = 1'b0;
    chk("wrap_ins2", 64'(w_ins), 64'h1002);
    chk("wrap_pcp4_2", 64'(w_pcp4), 64'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
